// File: rtl/msg_bram_arbiter_pkg.sv
// Shared types and defaults for the message BRAM arbiter.
package msg_arb_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PP_OWN  = 2'd1,
    NET_OWN = 2'd2,
    GAP     = 2'd3
  } arb_state_e;

  function automatic logic is_owned(arb_state_e s);
    return (s == PP_OWN) || (s == NET_OWN);
  endfunction

endpackage

// File: rtl/msg_bram_arbiter_if.sv
// Bundle of the PP/Net request side and the muxed BRAM port of the arbiter.
interface msg_bram_arbiter_if
  import msg_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              pp_req;
  logic              pp_done;
  logic [ADDR_W-1:0] pp_size;
  logic [ADDR_W-1:0] pp_addr;
  logic [DATA_W-1:0] pp_wdata;
  logic              pp_we;
  logic              net_req;
  logic              net_done;
  logic [ADDR_W-1:0] net_addr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_we;
  logic              busy_PP2Net;
  logic              busy_Net2PP;
  logic              msg_pending;
  logic [ADDR_W-1:0] msg_size;
  logic              msg_stored;
  logic              msg_accessed;
  logic              timeout_err;

  // Clients (PP, Net) drive requests and observe the arbiter.
  modport master (
    output pp_req, pp_done, pp_size, pp_addr, pp_wdata, pp_we,
    output net_req, net_done, net_addr,
    input  bram_addr, bram_wdata, bram_we, busy_PP2Net, busy_Net2PP,
    input  msg_pending, msg_size, msg_stored, msg_accessed, timeout_err
  );

  modport slave (
    input  pp_req, pp_done, pp_size, pp_addr, pp_wdata, pp_we,
    input  net_req, net_done, net_addr,
    output bram_addr, bram_wdata, bram_we, busy_PP2Net, busy_Net2PP,
    output msg_pending, msg_size, msg_stored, msg_accessed, timeout_err
  );

endinterface

// File: rtl/msg_bram_arbiter_hold_timer.sv
// Owned-cycle counter; expire flags the last permitted cycle of a grant.
module hold_timer #(
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (HOLD_TIMEOUT == 0) ? 1 : $clog2(HOLD_TIMEOUT + 1);

  generate
    if (HOLD_TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LIMIT = CW'(HOLD_TIMEOUT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Saturates at LIMIT so a lingering enable can never wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire = en && (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/msg_bram_arbiter.sv
// Mailbox arbiter: one message BRAM shared by a producer (PP) and a consumer (Net).
module msg_bram_arbiter
  import msg_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int HOLD_TIMEOUT = 4096,
  parameter int TURNAROUND   = 2
) (
  input logic               clk,
  input logic               reset_n,
  msg_bram_arbiter_if.slave bus
);

  localparam int              GW       = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(TURNAROUND - 1);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic              stored_q, stored_d;
  logic              accessed_q, accessed_d;
  logic              tmo_q, tmo_d;
  logic              busy_pp_q, busy_net_q;
  logic              owned;
  logic              expire;

  assign owned = is_owned(state_q);

  hold_timer #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_hold_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (!owned),
    .en     (owned),
    .expire (expire)
  );

  // Done is checked before req-drop and expiry so it always wins.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    pending_d  = pending_q;
    size_d     = size_q;
    stored_d   = 1'b0;
    accessed_d = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pp_req && !pending_q) begin
          state_d = PP_OWN;
        end else if (bus.net_req && pending_q) begin
          state_d = NET_OWN;
        end
      end
      PP_OWN: begin
        if (bus.pp_done) begin
          if (bus.pp_size != '0) begin
            size_d    = bus.pp_size;
            pending_d = 1'b1;
            stored_d  = 1'b1;
          end
          state_d = GAP;
        end else if (!bus.pp_req) begin
          state_d = GAP;
        end else if (expire) begin
          tmo_d   = 1'b1;
          state_d = GAP;
        end
      end
      NET_OWN: begin
        if (bus.net_done) begin
          pending_d  = 1'b0;
          accessed_d = 1'b1;
          state_d    = GAP;
        end else if (!bus.net_req) begin
          state_d = GAP;
        end else if (expire) begin
          tmo_d   = 1'b1;
          state_d = GAP;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      pending_q  <= 1'b0;
      size_q     <= '0;
      stored_q   <= 1'b0;
      accessed_q <= 1'b0;
      tmo_q      <= 1'b0;
      busy_pp_q  <= 1'b0;
      busy_net_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      size_q     <= size_d;
      stored_q   <= stored_d;
      accessed_q <= accessed_d;
      tmo_q      <= tmo_d;
      busy_pp_q  <= (state_d == PP_OWN);
      busy_net_q <= (state_d == NET_OWN);
    end
  end

  // Net is read-only, so its write enable is forced low.
  always_comb begin
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    bus.bram_we    = 1'b0;
    case (state_q)
      PP_OWN: begin
        bus.bram_addr  = bus.pp_addr;
        bus.bram_wdata = bus.pp_wdata;
        bus.bram_we    = bus.pp_we;
      end
      NET_OWN: begin
        bus.bram_addr = bus.net_addr;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy_PP2Net  = busy_pp_q;
  assign bus.busy_Net2PP  = busy_net_q;
  assign bus.msg_pending  = pending_q;
  assign bus.msg_size     = size_q;
  assign bus.msg_stored   = stored_q;
  assign bus.msg_accessed = accessed_q;
  assign bus.timeout_err  = tmo_q;

endmodule

// File: tb/tb_msg_bram_arbiter.sv
// Scenario tasks plus randomized traffic against a cycle-level mailbox model.
module tb_msg_bram_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int HT    = 30;
  localparam int TA    = 2;
  localparam int O_NONE = 0;
  localparam int O_PP   = 1;
  localparam int O_NET  = 2;

  typedef logic [60:0] vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  msg_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  msg_bram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .HOLD_TIMEOUT(HT), .TURNAROUND(TA)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the BRAM, how many cycles it has held it, idle cycles left before arbitration.
  int          m_owner;
  int          m_held;
  int          m_gap;
  logic          m_pending;
  logic [AW-1:0] m_size;
  logic          m_stored;
  logic          m_accessed;
  logic          m_tmo;

  function automatic void model_reset();
    m_owner = O_NONE; m_held = 0; m_gap = 0;
    m_pending = 1'b0; m_size = '0;
    m_stored = 1'b0; m_accessed = 1'b0; m_tmo = 1'b0;
  endfunction

  function automatic void model_release();
    m_owner = O_NONE;
    m_gap   = TA;
  endfunction

  function automatic void model_clock();
    m_stored = 1'b0; m_accessed = 1'b0; m_tmo = 1'b0;
    if (m_owner == O_NONE) begin
      if (m_gap > 0) m_gap--;
      else if (bus.pp_req && !m_pending) begin m_owner = O_PP; m_held = 0; end
      else if (bus.net_req && m_pending) begin m_owner = O_NET; m_held = 0; end
    end else if (m_owner == O_PP) begin
      if (bus.pp_done) begin
        if (bus.pp_size != 0) begin m_pending = 1'b1; m_size = bus.pp_size; m_stored = 1'b1; end
        model_release();
      end else if (!bus.pp_req) model_release();
      else if (m_held + 1 == HT) begin m_tmo = 1'b1; model_release(); end
      else m_held++;
    end else begin
      if (bus.net_done) begin m_pending = 1'b0; m_accessed = 1'b1; model_release(); end
      else if (!bus.net_req) model_release();
      else if (m_held + 1 == HT) begin m_tmo = 1'b1; model_release(); end
      else m_held++;
    end
  endfunction

  function automatic vec_t exp_vec();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    a = '0; d = '0; w = 1'b0;
    if (m_owner == O_PP) begin a = bus.pp_addr; d = bus.pp_wdata; w = bus.pp_we; end
    else if (m_owner == O_NET) a = bus.net_addr;
    return {m_owner == O_PP, m_owner == O_NET, m_pending, m_size,
            m_stored, m_accessed, m_tmo, a, d, w};
  endfunction

  function automatic vec_t act_vec();
    return {bus.busy_PP2Net, bus.busy_Net2PP, bus.msg_pending, bus.msg_size,
            bus.msg_stored, bus.msg_accessed, bus.timeout_err,
            bus.bram_addr, bus.bram_wdata, bus.bram_we};
  endfunction

  task automatic tick();
    if (!reset_n) model_reset(); else model_clock();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.pp_req = 0; bus.pp_done = 0; bus.pp_size = '0; bus.pp_addr = '0;
    bus.pp_wdata = '0; bus.pp_we = 0; bus.net_req = 0; bus.net_done = 0; bus.net_addr = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if (act_vec() !== '0) begin n_err++; $display("FAIL reset_outputs: got %h required 0", act_vec()); end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL reset_release: got %h required %h", act_vec(), exp_vec()); end
  endtask

  task automatic test_write_commit();
    logic [DW-1:0] wd;
    bus.pp_req = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy_PP2Net !== 1'b1) begin n_err++; $display("FAIL pp_grant_latency: got %b required 1", bus.busy_PP2Net); end
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      bus.pp_addr = AW'(i); bus.pp_wdata = wd; bus.pp_we = 1'b1;
      #1;
      n_cmp++;
      if ({bus.bram_addr, bus.bram_wdata, bus.bram_we} !== {AW'(i), wd, 1'b1}) begin
        n_err++; $display("FAIL pp_write[%0d]: got %h/%h/%b required %h/%h/1", i, bus.bram_addr, bus.bram_wdata, bus.bram_we, AW'(i), wd);
      end
      tick();
    end
    bus.pp_we = 1'b0; bus.pp_done = 1'b1; bus.pp_size = 11'd4;
    tick();
    bus.pp_done = 1'b0; bus.pp_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.msg_stored, bus.msg_pending, bus.msg_size, bus.busy_PP2Net} !== {1'b1, 1'b1, 11'd4, 1'b0}) begin
      n_err++; $display("FAIL commit: got stored=%b pend=%b size=%0d busy=%b required 1 1 4 0", bus.msg_stored, bus.msg_pending, bus.msg_size, bus.busy_PP2Net);
    end
    for (int i = 0; i < TA; i++) begin
      n_cmp++;
      if ({bus.busy_PP2Net, bus.busy_Net2PP} !== 2'b00) begin n_err++; $display("FAIL gap_grants[%0d]: got %b%b required 00", i, bus.busy_PP2Net, bus.busy_Net2PP); end
      tick();
    end
    n_cmp++;
    if ({bus.msg_stored, bus.msg_pending} !== 2'b01) begin n_err++; $display("FAIL stored_single_pulse: got stored=%b pend=%b required 0 1", bus.msg_stored, bus.msg_pending); end
  endtask

  task automatic test_read_consume();
    logic [AW-1:0] na;
    na = AW'($urandom_range(1, 2047));
    bus.net_req = 1'b1; bus.net_addr = na;
    bus.pp_we = 1'b1; bus.pp_addr = AW'($urandom); bus.pp_wdata = $urandom;
    tick();
    n_cmp++;
    if ({bus.busy_Net2PP, bus.busy_PP2Net, bus.bram_we, bus.bram_addr, bus.bram_wdata} !== {1'b1, 1'b0, 1'b0, na, 32'd0}) begin
      n_err++; $display("FAIL net_grant: got net=%b pp=%b we=%b addr=%h wd=%h required 1 0 0 %h 0", bus.busy_Net2PP, bus.busy_PP2Net, bus.bram_we, bus.bram_addr, bus.bram_wdata, na);
    end
    repeat (2) tick();
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0; bus.net_req = 1'b0; bus.pp_we = 1'b0;
    #1;
    n_cmp++;
    if ({bus.msg_accessed, bus.msg_pending, bus.msg_stored, bus.busy_Net2PP} !== 4'b1000) begin
      n_err++; $display("FAIL consume: got acc=%b pend=%b stored=%b busy=%b required 1 0 0 0", bus.msg_accessed, bus.msg_pending, bus.msg_stored, bus.busy_Net2PP);
    end
    tick();
    n_cmp++;
    if (bus.msg_accessed !== 1'b0) begin n_err++; $display("FAIL accessed_single_pulse: got %b required 0", bus.msg_accessed); end
  endtask

  task automatic test_both_requests();
    logic [AW-1:0] sz;
    int            cnt;
    bus.pp_req = 1'b1;
    for (int k = 0; k < 20 && m_owner != O_PP; k++) tick();
    n_cmp++;
    if (bus.busy_PP2Net !== 1'b1) begin n_err++; $display("FAIL both_setup_grant: got %b required 1", bus.busy_PP2Net); end
    sz = AW'($urandom_range(1, 2047));
    bus.pp_done = 1'b1; bus.pp_size = sz;
    tick();
    bus.pp_done = 1'b0; bus.net_req = 1'b1;
    for (int k = 0; k < 20 && m_owner == O_NONE; k++) tick();
    n_cmp++;
    if ({bus.busy_Net2PP, bus.busy_PP2Net, bus.msg_size} !== {1'b1, 1'b0, sz}) begin
      n_err++; $display("FAIL both_net_first: got net=%b pp=%b size=%h required 1 0 %h", bus.busy_Net2PP, bus.busy_PP2Net, bus.msg_size, sz);
    end
    repeat (2) tick();
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0; bus.net_req = 1'b0;
    // TA gap cycles, then one arbitration cycle in IDLE before PP is granted.
    cnt = 0;
    while (bus.busy_PP2Net !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_cmp++;
    if (cnt !== TA + 1) begin n_err++; $display("FAIL both_pp_after_net: got %0d cycles required %0d", cnt, TA + 1); end
    bus.pp_done = 1'b1; bus.pp_size = '0;
    tick();
    bus.pp_done = 1'b0; bus.pp_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.msg_stored, bus.msg_pending, bus.busy_PP2Net, bus.msg_size} !== {3'b000, sz}) begin
      n_err++; $display("FAIL zero_size_done: got stored=%b pend=%b busy=%b size=%h required 0 0 0 %h", bus.msg_stored, bus.msg_pending, bus.busy_PP2Net, bus.msg_size, sz);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    int n_tmo;
    bus.pp_req = 1'b1;
    for (int k = 0; k < 20 && m_owner != O_PP; k++) tick();
    cnt = 0;
    while (bus.busy_PP2Net === 1'b1 && cnt < 100) begin cnt++; tick(); end
    n_tmo = int'(bus.timeout_err);
    bus.pp_req = 1'b0;
    n_cmp++;
    if (cnt !== HT) begin n_err++; $display("FAIL timeout_hold: got %0d cycles required %0d", cnt, HT); end
    repeat (5) begin tick(); n_tmo += int'(bus.timeout_err); end
    n_cmp++;
    if (n_tmo !== 1) begin n_err++; $display("FAIL timeout_pulse: got %0d pulses required 1", n_tmo); end
    n_cmp++;
    if ({bus.msg_pending, bus.msg_stored} !== 2'b00) begin n_err++; $display("FAIL timeout_pending: got pend=%b stored=%b required 0 0", bus.msg_pending, bus.msg_stored); end
  endtask

  task automatic test_done_at_timeout();
    logic [AW-1:0] sz;
    bus.pp_req = 1'b1;
    for (int k = 0; k < 20 && m_owner != O_PP; k++) tick();
    repeat (HT - 1) tick();
    n_cmp++;
    if (bus.busy_PP2Net !== 1'b1) begin n_err++; $display("FAIL last_cycle_owned: got %b required 1", bus.busy_PP2Net); end
    sz = AW'($urandom_range(1, 2047));
    bus.pp_done = 1'b1; bus.pp_size = sz;
    tick();
    bus.pp_done = 1'b0; bus.pp_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.msg_stored, bus.timeout_err, bus.msg_pending, bus.msg_size, bus.busy_PP2Net} !== {3'b101, sz, 1'b0}) begin
      n_err++; $display("FAIL done_at_timeout: got stored=%b tmo=%b pend=%b size=%h busy=%b required 1 0 1 %h 0", bus.msg_stored, bus.timeout_err, bus.msg_pending, bus.msg_size, bus.busy_PP2Net, sz);
    end
  endtask

  task automatic test_async_reset();
    bus.net_req = 1'b1; bus.net_addr = AW'($urandom_range(1, 2047));
    bus.pp_addr = AW'($urandom); bus.pp_wdata = $urandom; bus.pp_we = 1'b1;
    for (int k = 0; k < 20 && m_owner != O_NET; k++) tick();
    n_cmp++;
    if (bus.busy_Net2PP !== 1'b1) begin n_err++; $display("FAIL pre_reset_net_grant: got %b required 1", bus.busy_Net2PP); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (act_vec() !== '0) begin n_err++; $display("FAIL async_reset: got %h required 0", act_vec()); end
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1; bus.net_req = 1'b0; bus.pp_we = 1'b0;
    tick();
    n_cmp++;
    if (act_vec() !== exp_vec() || bus.msg_pending !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got %h required %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    vec_t e;
    vec_t a;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.pp_req = ~bus.pp_req;
      if ($urandom_range(0, 15) == 0) bus.net_req = ~bus.net_req;
      bus.pp_done  = ($urandom_range(0, 39) == 0);
      bus.net_done = ($urandom_range(0, 39) == 0);
      bus.pp_size  = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      bus.pp_addr  = AW'($urandom);
      bus.pp_wdata = $urandom;
      bus.pp_we    = 1'($urandom_range(0, 1));
      bus.net_addr = AW'($urandom);
      #1;
      e = exp_vec();
      a = act_vec();
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL random cyc %0d: got %h required %h", i, a, e); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_read_consume();
    test_both_requests();
    test_timeout();
    test_done_at_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
